mc_control_seq: RTL

- Parametrised successor to the single-cycle-per-state multicycle MIPS control FSM.
- Sequences fetch, decode, execute, memory and write-back for the core's R, I and J subset.
- Adds configurable memory wait states, multi-cycle mult/div stalls, and a full exception-entry sequence (opcode, overflow, div-by-zero).
- Drives the datapath muxes and write enables; sits between the instruction register and the datapath.

---
 rtl/mc_control_seq.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_seq.sv
// mc_control_seq: multicycle MIPS control sequencer with memory wait states,
// multi-cycle mult/div stalls and an exception-entry sequence.
module mc_control_seq #(
  parameter int MEM_WAIT  = 3,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       ovf,
  input  logic       div0,
  input  logic       alu_zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [2:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       aluout_write,
  output logic [2:0] pc_source,
  output logic [1:0] excp_sel,
  output logic       epc_write,
  output logic       md_start,
  output logic       hilo_write,
  output logic [3:0] state_o,
  output logic       reset_out
);

  localparam int MEM_W = (MEM_WAIT < 1) ? 1 : MEM_WAIT;
  localparam int MD_C  = (MD_CYCLES < 1) ? 1 : MD_CYCLES;

  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_W - 1);
  localparam logic [CNT_W-1:0] MEM_END  = CNT_W'(MEM_W);
  localparam logic [CNT_W-1:0] MD_LAST  = CNT_W'(MD_C - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_SLT  = 6'h2A;

  localparam logic [1:0] EXCP_OPC  = 2'b00;
  localparam logic [1:0] EXCP_OVF  = 2'b01;
  localparam logic [1:0] EXCP_DIV0 = 2'b10;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_WB_R   = 4'd4,
    S_EXEC_I = 4'd5,
    S_WB_I   = 4'd6,
    S_MD     = 4'd7,
    S_ADDR   = 4'd8,
    S_MEM_RD = 4'd9,
    S_WB_MEM = 4'd10,
    S_MEM_WR = 4'd11,
    S_BRANCH = 4'd12,
    S_EXCP   = 4'd13
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       excp_q, excp_next;

  // State, shared wait counter and latched exception cause; the counter
  // restarts on every state change so each state counts its own cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_RESET;
      cnt    <= '0;
      excp_q <= EXCP_OPC;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state) ? '0 : cnt + CNT_W'(1);
      if (state_next == S_EXCP && state != S_EXCP)
        excp_q <= excp_next;
    end
  end

  // Next-state selection and exception cause for entry into EXCP.
  always_comb begin
    state_next = state;
    excp_next  = EXCP_OPC;
    case (state)
      S_RESET:  state_next = S_FETCH;
      S_FETCH:  if (cnt == MEM_LAST) state_next = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_RTYPE) begin
          case (funct)
            F_ADD, F_SUB, F_AND, F_SLT: state_next = S_EXEC_R;
            F_MULT, F_DIV:              state_next = S_MD;
            F_JR:                       state_next = S_FETCH;
            default:                    state_next = S_EXCP;
          endcase
        end else begin
          case (opcode)
            OP_ADDI:       state_next = S_EXEC_I;
            OP_LW, OP_SW:  state_next = S_ADDR;
            OP_BEQ, OP_BNE: state_next = S_BRANCH;
            OP_J:          state_next = S_FETCH;
            default:       state_next = S_EXCP;
          endcase
        end
      end
      S_EXEC_R: begin
        if (ovf && (funct == F_ADD || funct == F_SUB)) begin
          state_next = S_EXCP;
          excp_next  = EXCP_OVF;
        end else begin
          state_next = S_WB_R;
        end
      end
      S_WB_R:   state_next = S_FETCH;
      S_EXEC_I: begin
        if (ovf) begin
          state_next = S_EXCP;
          excp_next  = EXCP_OVF;
        end else begin
          state_next = S_WB_I;
        end
      end
      S_WB_I:   state_next = S_FETCH;
      S_MD: begin
        if (cnt == '0 && div0 && funct == F_DIV) begin
          state_next = S_EXCP;
          excp_next  = EXCP_DIV0;
        end else if (cnt == MD_LAST) begin
          state_next = S_FETCH;
        end
      end
      S_ADDR:   state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (cnt == MEM_LAST) state_next = S_WB_MEM;
      S_WB_MEM: state_next = S_FETCH;
      S_MEM_WR: state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_EXCP:   if (cnt == MEM_END) state_next = S_FETCH;
      default:  state_next = S_RESET;
    endcase
  end

  // Datapath controls decoded from state and counter (plus IR fields).
  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    iord         = 2'b00;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_op       = 3'b000;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    aluout_write = 1'b0;
    pc_source    = 3'b000;
    excp_sel     = 2'b00;
    epc_write    = 1'b0;
    md_start     = 1'b0;
    hilo_write   = 1'b0;
    state_o      = state;
    reset_out    = (state == S_RESET);
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_op    = 3'b001;
        alu_src_b = 2'b01;
        if (cnt == MEM_LAST) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
        end
      end
      S_DECODE: begin
        alu_op       = 3'b001;
        alu_src_b    = 2'b11;
        aluout_write = 1'b1;
        if (opcode == OP_RTYPE && funct == F_JR) begin
          pc_write  = 1'b1;
          pc_source = 3'b011;
        end else if (opcode == OP_J) begin
          pc_write  = 1'b1;
          pc_source = 3'b010;
        end
      end
      S_EXEC_R: begin
        alu_src_a    = 2'b01;
        aluout_write = 1'b1;
        case (funct)
          F_ADD:   alu_op = 3'b001;
          F_SUB:   alu_op = 3'b010;
          F_AND:   alu_op = 3'b011;
          F_SLT:   alu_op = 3'b111;
          default: alu_op = 3'b000;
        endcase
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        alu_op       = 3'b001;
        aluout_write = 1'b1;
      end
      S_WB_I: reg_write = 1'b1;
      S_MD: begin
        md_start   = (cnt == '0);
        hilo_write = (cnt == MD_LAST);
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 2'b01;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 3'b010;
        pc_source = 3'b001;
        pc_write  = (opcode == OP_BNE) ? !alu_zero : alu_zero;
      end
      S_EXCP: begin
        excp_sel = excp_q;
        if (cnt == '0) begin
          epc_write = 1'b1;
          alu_op    = 3'b010;
          alu_src_b = 2'b01;
        end else begin
          mem_read = 1'b1;
          iord     = 2'b10;
          if (cnt == MEM_END) begin
            pc_write  = 1'b1;
            pc_source = 3'b100;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
